// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, STOP.
// Each bus bit is four quarters of CLK_DIV clocks; scl is low in Q0-Q1 and high in Q2-Q3.
module i2c_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  state_t     state, nxt_state;
  logic [9:0] div_cnt, nxt_cnt;
  logic [1:0] quarter, nxt_q;
  logic [2:0] bit_cnt, nxt_bit;
  logic [7:0] tx_addr, tx_data, rx_shift;
  logic       sda_oe, nxt_oe, nxt_scl;
  logic       tick, bit_end, sample, sda_in, stop_last;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    bit_end   = tick && (quarter == 2'd3);
    sample    = tick && (quarter == 2'd2);
    nxt_state = state;
    nxt_cnt   = div_cnt;
    nxt_q     = quarter;
    nxt_bit   = bit_cnt;
    if (state == IDLE) begin
      if (start) begin
        nxt_state = START;
        nxt_cnt   = '0;
        nxt_q     = '0;
        nxt_bit   = 3'd7;
      end
    end else begin
      nxt_cnt = tick ? '0 : div_cnt + 10'd1;
      if (tick)
        nxt_q = quarter + 2'd1;
      if (bit_end) begin
        // bit_cnt wraps 0 -> 7, so the next byte phase starts at its MSB for free
        nxt_bit = bit_cnt - 3'd1;
        case (state)
          START:     begin nxt_state = ADDR; nxt_bit = 3'd7; end
          ADDR:      if (bit_cnt == 3'd0) nxt_state = ADDR_ACK;
          ADDR_ACK:  begin
                       nxt_bit   = 3'd7;
                       nxt_state = ack_err ? STOP : (tx_addr[0] ? READ : WRITE);
                     end
          WRITE:     if (bit_cnt == 3'd0) nxt_state = WRITE_ACK;
          WRITE_ACK: nxt_state = STOP;
          READ:      if (bit_cnt == 3'd0) nxt_state = READ_ACK;
          READ_ACK:  nxt_state = STOP;
          default:   nxt_state = IDLE;
        endcase
      end
    end

    // Bus pins are registered from the state/quarter being entered, so a data
    // bit only ever changes at Q0 entry because nxt_bit is constant within a bit.
    nxt_scl = (nxt_state == IDLE) || nxt_q[1];
    case (nxt_state)
      START:   nxt_oe = nxt_q[1];
      ADDR:    nxt_oe = ~tx_addr[nxt_bit];
      WRITE:   nxt_oe = ~tx_data[nxt_bit];
      STOP:    nxt_oe = (nxt_q != 2'd3);
      default: nxt_oe = 1'b0;
    endcase

    stop_last = (state == STOP) && (nxt_q == 2'd3) && (nxt_cnt == DIV_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      quarter  <= '0;
      bit_cnt  <= '0;
      tx_addr  <= '0;
      tx_data  <= '0;
      rx_shift <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      state   <= nxt_state;
      div_cnt <= nxt_cnt;
      quarter <= nxt_q;
      bit_cnt <= nxt_bit;
      scl     <= nxt_scl;
      sda_oe  <= nxt_oe;
      done    <= stop_last;
      if (stop_last)
        busy <= 1'b0;
      if (state == IDLE && start) begin
        tx_addr <= {addr, rw};
        tx_data <= wdata;
        ack_err <= 1'b0;
        busy    <= 1'b1;
      end
      if (sample) begin
        case (state)
          ADDR_ACK, WRITE_ACK: if (sda_in) ack_err <= 1'b1;
          READ:                rx_shift <= {rx_shift[6:0], sda_in};
          default:             ;
        endcase
      end
      if (state == READ && nxt_state == READ_ACK)
        rdata <= rx_shift;
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a time-indexed bus model predicts scl/sda/busy/done each
// cycle; a scripted open-drain target supplies ACKs and read data.
module tb_i2c_master;
  localparam int unsigned D   = 4;
  localparam int unsigned BIT = 4 * D;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       busy, done, ack_err, scl;
  logic       tgt_low = 1'b0;
  wire        sda;

  assign sda = tgt_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int unsigned cyc = 0;

  // target behaviour applied to the next accepted transaction
  logic [7:0] nx_tdata = '0;
  bit nx_present = 1, nx_dack = 1;

  // transaction in flight: m_k is the clk index since START entry
  bit          m_active = 0, m_rw = 0, m_present = 0, m_dack = 0, m_ack_err = 0;
  int unsigned m_k = 0, m_n = 0;
  logic [7:0]  m_byte0 = '0, m_wdata = '0, m_tdata = '0;

  // pure bus observation
  bit          prev_scl = 1, prev_sda = 1, prev_busy = 0, measuring = 0;
  int unsigned run = 0, busy_rise = 0, lat = 0, done_cnt = 0;
  logic [7:0]  rdata_at_done = '0;
  bit          bits_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_sda(input int unsigned k);
    int unsigned b, q;
    b = k / BIT;
    q = (k % BIT) / D;
    if (b == 0)             return q < 2;
    if (b <= 8)             return m_byte0[8 - b];
    if (b == 9)             return !m_present;
    if (b == m_n / BIT - 1) return q == 3;
    if (b <= 17)            return m_rw ? m_tdata[17 - b] : m_wdata[17 - b];
    return m_rw ? 1'b1 : !m_dack;
  endfunction

  function automatic bit tgt_pull(input int unsigned k);
    int unsigned b;
    b = k / BIT;
    if (!m_present)                   return 1'b0;
    if (b == 9)                       return 1'b1;
    if (m_rw && b >= 10 && b <= 17)   return !m_tdata[17 - b];
    if (!m_rw && b == 18)             return m_dack;
    return 1'b0;
  endfunction

  function automatic logic [7:0] byte_at(input int s);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      v = {v[6:0], (s + i < bits_q.size()) ? bits_q[s + i] : 1'b0};
    return v;
  endfunction

  task automatic compare();
    int unsigned q;
    if (!m_active) begin
      chk("scl_idle", scl, 1);
      chk("sda_idle", sda, 1);
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
      chk("ack_err_idle", ack_err, m_ack_err);
    end else begin
      q = (m_k % BIT) / D;
      chk("scl", scl, q >= 2);
      chk("sda", sda, exp_sda(m_k));
      chk("busy", busy, m_k < m_n - 1);
      chk("done", done, m_k == m_n - 1);
      if (m_k == 0) chk("ack_err_clear", ack_err, 0);
      if (m_k == m_n - 1) begin
        m_ack_err = !m_present || (!m_rw && !m_dack);
        chk("ack_err", ack_err, m_ack_err);
        if (m_rw && m_present) chk("rdata", rdata, m_tdata);
      end
    end

    if (rst) begin
      measuring = 0;
      run = 0;
    end else begin
      if (m_active && prev_scl && scl && (m_k / BIT != m_n / BIT - 1))
        chk("sda_stable_scl_high", sda, prev_sda);
      if (m_active) begin
        if (scl == prev_scl) run++;
        else begin
          if (measuring) chk("scl_phase", run, 2 * D);
          run = 1;
          measuring = 1;
        end
        if (m_k == m_n - 1) begin
          chk("scl_phase_stop", run, 2 * D);
          measuring = 0;
        end
      end
    end

    if (busy && !prev_busy) begin
      bits_q.delete();
      busy_rise = cyc;
    end
    if (busy && !prev_scl && scl) bits_q.push_back(sda);
    if (done === 1'b1) begin
      done_cnt++;
      lat = cyc - busy_rise + 1;
      rdata_at_done = rdata;
    end
    prev_scl  = scl;
    prev_sda  = sda;
    prev_busy = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_active  = 0;
      m_ack_err = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == m_n) m_active = 0;
    end else if (start) begin
      m_active  = 1;
      m_k       = 0;
      m_byte0   = {addr, rw};
      m_rw      = rw;
      m_wdata   = wdata;
      m_tdata   = nx_tdata;
      m_present = nx_present;
      m_dack    = nx_dack;
      m_n       = (nx_present ? 20 : 11) * BIT;
    end
    tgt_low = m_active && tgt_pull(m_k);
    @(negedge clk);
    compare();
  endtask

  task automatic launch(input logic [6:0] a, input logic r, input logic [7:0] wd,
                        input logic [7:0] td, input bit pres, input bit dack);
    addr = a; rw = r; wdata = wd;
    nx_tdata = td; nx_present = pres; nx_dack = dack;
    done_cnt = 0;
    start = 1;
    tick();
    start = 0;
    addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
  endtask

  task automatic wait_done(input int unsigned poke_at, input bit hold_on_done);
    bit got;
    got = 0;
    for (int i = 0; i < 25 * BIT && !got; i++) begin
      if (poke_at != 0 && m_active && m_k == poke_at) begin
        start = 1; addr = 7'h12; rw = 0;
      end else start = 0;
      tick();
      if (done === 1'b1) got = 1;
    end
    chk("done_seen", got, 1);
    start = hold_on_done;
    if (!hold_on_done) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_scl", scl, 1);
    chk("reset_sda", sda, 1);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_ack_err", ack_err, 0);

    // write with ACKing target
    launch(7'h77, 1'b0, 8'h5A, 8'h00, 1, 1);
    wait_done(0, 0);
    chk("w_bits", bits_q.size(), 20);
    chk("w_addr_byte", byte_at(1), 8'hEE);
    chk("w_data_byte", byte_at(10), 8'h5A);
    chk("w_latency", lat, 320);
    chk("w_ack_err", ack_err, 0);
    chk("w_done_pulses", done_cnt, 1);

    // read, target returns AA, master NACKs
    launch(7'h77, 1'b1, 8'h00, 8'hAA, 1, 1);
    wait_done(0, 0);
    chk("r_addr_byte", byte_at(1), 8'hEF);
    chk("r_data_byte", byte_at(10), 8'hAA);
    chk("r_master_nack", bits_q.size() > 18 ? bits_q[18] : 1'b0, 1);
    chk("r_rdata", rdata_at_done, 8'hAA);
    chk("r_latency", lat, 320);

    // address NACK, no target
    launch(7'h12, 1'b0, 8'h00, 8'h00, 0, 0);
    wait_done(0, 0);
    chk("n_bits", bits_q.size(), 11);
    chk("n_ack_bit", bits_q.size() > 9 ? bits_q[9] : 1'b0, 1);
    chk("n_ack_err", ack_err, 1);
    chk("n_latency", lat, 176);

    // second start mid-ADDR is ignored
    launch(7'h77, 1'b0, 8'h5A, 8'h00, 1, 1);
    wait_done(3 * BIT, 0);
    chk("lockout_addr", byte_at(1), 8'hEE);
    chk("lockout_done_pulses", done_cnt, 1);

    // start coincident with done is taken one clk later
    launch(7'h77, 1'b0, 8'h3C, 8'h00, 1, 1);
    wait_done(0, 1);
    addr = 7'h77; rw = 1'b1; nx_tdata = 8'h96; nx_present = 1; nx_dack = 1;
    tick();
    chk("start_on_done_ignored", busy, 0);
    tick();
    chk("start_after_done_taken", busy, 1);
    start = 0;
    wait_done(0, 0);
    chk("chained_rdata", rdata_at_done, 8'h96);

    // asynchronous reset during WRITE bit 3
    launch(7'h77, 1'b0, 8'hC3, 8'h00, 1, 1);
    while (m_active && m_k < 14 * BIT + D + 1) tick();
    #2;
    rst = 1;
    m_active = 0;
    m_ack_err = 0;
    tgt_low = 0;
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 8'h00);
    prev_scl = scl; prev_sda = sda; prev_busy = busy; measuring = 0;
    tick();
    tick();
    rst = 0;
    tick();
    launch(7'h77, 1'b0, 8'h5A, 8'h00, 1, 1);
    wait_done(0, 0);
    chk("post_rst_data_byte", byte_at(10), 8'h5A);
    chk("post_rst_latency", lat, 320);
    chk("post_rst_ack_err", ack_err, 0);

    // randomized transactions, some with ignored mid-transfer start pulses
    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 4)) tick();
      launch(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
      wait_done($urandom_range(0, 1) != 0 ? $urandom_range(1, 8 * BIT) : 0, 0);
      chk("rand_done_pulses", done_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCL quarter-period; legal range 2..1023.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  command strobe; sampled only while busy=0.
REQ-005 addr  input  7  target address; captured with start.
REQ-006 rw  input  1  transfer direction; 1=read, 0=write; captured with start.
REQ-007 wdata  input  8  write byte; captured with start.
REQ-008 rdata  output  8  byte read from the target; valid when done=1 and rw=1.
REQ-009 busy  output  1  transaction in progress.
REQ-010 done  output  1  one-clk pulse at transaction end.
REQ-011 ack_err  output  1  target NACK seen; valid with done, held until next start.
REQ-012 scl  output  1  I2C clock, push-pull, idles at 1.
REQ-013 sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else high-Z (external pull-up).

Function
REQ-014 Every bus bit lasts 4 quarters (Q0..Q3) of CLK_DIV clks each; scl=0 in Q0-Q1 and scl=1 in Q2-Q3.
REQ-015 Master changes sda only on entry to Q0 and samples sda on the last clk of Q2.
REQ-016 States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP.
REQ-017 IDLE: scl=1, sda released, busy=0; start=1 captures addr/rw/wdata, clears ack_err, sets busy=1 and goes to START on the next clk.
REQ-018 START: one bit time; sda released for Q0-Q1, pulled low at Q2 while scl=1, held to Q3 end.
REQ-019 ADDR: 8 bits, MSB first: addr[6:0], then rw.
REQ-020 ADDR_ACK: sda released; sampled 0 -> WRITE if rw=0, else READ; sampled 1 -> ack_err=1, go to STOP.
REQ-021 WRITE: 8 bits of wdata, MSB first, then WRITE_ACK.
REQ-022 WRITE_ACK: sda released; sampled 1 sets ack_err; always go to STOP.
REQ-023 READ: sda released; 8 samples shifted in MSB first into a shift register.
REQ-024 READ_ACK: master releases sda (NACK, single-byte read); rdata loads the shift register at the Q0 entry; then STOP.
REQ-025 STOP: one bit time; sda pulled low in Q0-Q1, scl rises at Q2, sda released at Q3 entry while scl=1.
REQ-026 At the STOP bit's final clk: done=1 for one clk and busy=0; the state returns to IDLE on the next clk.
REQ-027 A start asserted while busy=1 is ignored; no queuing.
REQ-028 A start asserted on the same clk as the done pulse is ignored; it is accepted on the following clk.
REQ-029 Bit counter is 3 bits and counts 7 down to 0; a state is left after bit 0.
REQ-030 Arbitration and clock stretching are not supported; scl is never sampled.
REQ-031 A write transaction totals 1 START, 8 ADDR, 1 ACK, 8 WRITE, 1 ACK and 1 STOP bit = 20 bit times = 80*CLK_DIV clks from START entry to done.
REQ-032 A read transaction also totals 20 bit times.
REQ-033 A NACKed address totals 11 bit times.

Reset
REQ-034 rst=1 forces, immediately and regardless of clk: state IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, rdata=8'h00, and clears the divider and bit counters.
REQ-035 rst asserted mid-transaction releases the bus without generating a STOP.
REQ-036 After rst deasserts, the first start is accepted normally.

Verification
REQ-037 Write: start with addr=7'h77, rw=0, wdata=8'h5A, and a target that ACKs -> bus carries byte 8'hEE then 8'h5A; done after 80*CLK_DIV clks; ack_err=0.
REQ-038 Read: start with addr=7'h77, rw=1, target returns 8'hAA -> bus carries byte 8'hEF; rdata=8'hAA at done; master NACKs on the 9th data clock; STOP follows.
REQ-039 Address NACK: start with addr=7'h12 and no target -> ack_err=1; STOP follows directly after the address ACK bit; done at 44*CLK_DIV clks.
REQ-040 Busy lockout: pulse start again mid-ADDR with different addr -> the bus carries only the first address; exactly one done pulse.
REQ-041 Reset mid-WRITE: assert rst during bit 3 -> scl=1 and sda released within the same clk; busy=0; a new write then completes correctly.
REQ-042 Timing checker across all tests: sda never changes while scl=1 except at START and STOP edges; every scl high and low phase lasts exactly 2*CLK_DIV clks.
